// File: rtl/add_sub_chk_if.sv
// Bus between the adder stimulus/response side and add_sub_checker.
// The master drives operands and adder results; the slave reports check status.
interface add_sub_chk_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             v;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic             first_err_valid;
  logic [WIDTH-1:0] first_err_x;
  logic [WIDTH-1:0] first_err_y;
  logic             first_err_cin;
  logic             done;

  modport master (
    output start, in_valid, x, y, cin, sum, cout, v,
    input  mismatch, err_cnt, vec_cnt, first_err_valid,
           first_err_x, first_err_y, first_err_cin, done
  );

  modport slave (
    input  start, in_valid, x, y, cin, sum, cout, v,
    output mismatch, err_cnt, vec_cnt, first_err_valid,
           first_err_x, first_err_y, first_err_cin, done
  );
endinterface

// File: rtl/add_sub_checker.sv
// Response checker for the adder/subtractor self-test sweep: recomputes each result,
// counts vectors/errors and captures the first failure. ADD_SUB_CHK_COUT_EN adds cout to the compare.
module add_sub_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  add_sub_chk_if.slave bus
);

  localparam int TOTAL = 2 ** (2 * WIDTH + 1);
  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic             mismatch_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] vec_cnt_r;
  logic             first_err_valid_r;
  logic [WIDTH-1:0] first_err_x_r;
  logic [WIDTH-1:0] first_err_y_r;
  logic             first_err_cin_r;
  logic             done_r;

  logic [WIDTH-1:0] yy_s;
  logic [WIDTH:0]   full_s;
  logic [WIDTH-1:0] low_s;
  logic             exp_v_s;
  logic             bad_s;
  logic [CNT_W-1:0] vec_inc_s;
  logic [CNT_W-1:0] err_inc_s;

  // Reference result, compare against the adder, and saturating counter increments
  always_comb begin
    yy_s      = bus.cin ? ~bus.y : bus.y;
    full_s    = {1'b0, bus.x} + {1'b0, yy_s} + {{WIDTH{1'b0}}, bus.cin};
    // low_s MSB is the carry into the operand MSB
    low_s     = {1'b0, bus.x[WIDTH-2:0]} + {1'b0, yy_s[WIDTH-2:0]}
              + {{(WIDTH-1){1'b0}}, bus.cin};
    exp_v_s   = low_s[WIDTH-1] ^ full_s[WIDTH];
`ifdef ADD_SUB_CHK_COUT_EN
    bad_s     = (bus.sum != full_s[WIDTH-1:0]) || (bus.v != exp_v_s)
              || (bus.cout != full_s[WIDTH]);
`else
    bad_s     = (bus.sum != full_s[WIDTH-1:0]) || (bus.v != exp_v_s);
`endif
    vec_inc_s = (&vec_cnt_r) ? vec_cnt_r : vec_cnt_r + CNT_ONE;
    err_inc_s = (&err_cnt_r) ? err_cnt_r : err_cnt_r + CNT_ONE;
  end

  // Sweep FSM with registered status outputs; start overrides any same-cycle vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      mismatch_r        <= 1'b0;
      err_cnt_r         <= '0;
      vec_cnt_r         <= '0;
      first_err_valid_r <= 1'b0;
      first_err_x_r     <= '0;
      first_err_y_r     <= '0;
      first_err_cin_r   <= 1'b0;
      done_r            <= 1'b0;
    end else if (bus.start) begin
      state_r           <= ST_RUN;
      mismatch_r        <= 1'b0;
      err_cnt_r         <= '0;
      vec_cnt_r         <= '0;
      first_err_valid_r <= 1'b0;
      first_err_x_r     <= '0;
      first_err_y_r     <= '0;
      first_err_cin_r   <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mismatch_r <= 1'b0;
        end
        ST_RUN: begin
          if (bus.in_valid) begin
            vec_cnt_r  <= vec_inc_s;
            mismatch_r <= bad_s;
            if (bad_s) begin
              err_cnt_r <= err_inc_s;
              if (!first_err_valid_r) begin
                first_err_valid_r <= 1'b1;
                first_err_x_r     <= bus.x;
                first_err_y_r     <= bus.y;
                first_err_cin_r   <= bus.cin;
              end
            end
            // Done appears together with the last vector's result
            if (vec_inc_s == TOTAL_CNT) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            mismatch_r <= 1'b0;
          end
        end
        ST_DONE: begin
          mismatch_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          mismatch_r <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mismatch        = mismatch_r;
  assign bus.err_cnt         = err_cnt_r;
  assign bus.vec_cnt         = vec_cnt_r;
  assign bus.first_err_valid = first_err_valid_r;
  assign bus.first_err_x     = first_err_x_r;
  assign bus.first_err_y     = first_err_y_r;
  assign bus.first_err_cin   = first_err_cin_r;
  assign bus.done            = done_r;

endmodule

// File: tb/tb_add_sub_checker.sv
// Self-checking bench for add_sub_checker: directed cases, full sweeps and random vectors
// against an arithmetic reference model; honours ADD_SUB_CHK_COUT_EN.
module tb_add_sub_checker;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  add_sub_chk_if #(.WIDTH(4), .CNT_W(16)) bus ();

  add_sub_checker #(.WIDTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what the outputs should show after the current cycle
  logic        m_mis, m_done, m_run, m_fv, m_fc;
  logic [15:0] m_err, m_vec;
  logic [3:0]  m_fx, m_fy;

  // {cout, v, sum} of a correct adder, from integer arithmetic
  function automatic logic [5:0] ref_result(input logic [3:0] a, input logic [3:0] b, input logic c);
    int sa, sb, u, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (c) begin
      u = int'(a) - int'(b);
      s = sa - sb;
    end else begin
      u = int'(a) + int'(b);
      s = sa + sb;
    end
    ref_result[3:0] = 4'(u);
    ref_result[4]   = (s > 7) || (s < -8);
    ref_result[5]   = c ? (a >= b) : (u > 15);
  endfunction

  task automatic model_clear();
    m_mis = 1'b0; m_done = 1'b0; m_fv = 1'b0; m_fc = 1'b0;
    m_err = 16'd0; m_vec = 16'd0; m_fx = 4'd0; m_fy = 4'd0;
  endtask

  // Drive one cycle of stimulus, advance the model, and move to the next negedge
  task automatic cycle(input logic st, input logic vl, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [3:0] s, input logic co, input logic ov);
    logic [5:0] r;
    logic       bad;
    bus.start = st; bus.in_valid = vl; bus.x = a; bus.y = b;
    bus.cin = c; bus.sum = s; bus.cout = co; bus.v = ov;
    r   = ref_result(a, b, c);
    bad = (s !== r[3:0]) || (ov !== r[4]);
`ifdef ADD_SUB_CHK_COUT_EN
    bad = bad || (co !== r[5]);
`endif
    if (st) begin
      model_clear();
      m_run = 1'b1;
    end else if (m_run && vl) begin
      if (m_vec != 16'hFFFF) m_vec = m_vec + 16'd1;
      m_mis = bad;
      if (bad) begin
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        if (!m_fv) begin
          m_fv = 1'b1; m_fx = a; m_fy = b; m_fc = c;
        end
      end
      if (m_vec == 16'd512) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end else begin
      m_mis = 1'b0;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic good_vec(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [5:0] r;
    r = ref_result(a, b, c);
    cycle(1'b0, 1'b1, a, b, c, r[3:0], r[5], r[4]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    m_run = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.x = 4'd0; bus.y = 4'd0;
    bus.cin = 1'b0; bus.sum = 4'd0; bus.cout = 1'b0; bus.v = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.mismatch, bus.err_cnt, bus.vec_cnt, bus.done, bus.first_err_valid,
         bus.first_err_x, bus.first_err_y, bus.first_err_cin} !== 44'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got mis=%0b err=%0d vec=%0d done=%0b fv=%0b, want all 0",
               bus.mismatch, bus.err_cnt, bus.vec_cnt, bus.done, bus.first_err_valid);
    end
    // IDLE ignores vectors
    cycle(1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    tests_run++;
    if ({bus.vec_cnt, bus.err_cnt} !== 32'd0) begin
      tests_failed++;
      $display("FAIL idle_ignores: got vec=%0d err=%0d, want 0 0", bus.vec_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    tests_run++;
    if ({bus.mismatch, bus.vec_cnt, bus.err_cnt} !== {1'b0, 16'd1, 16'd0}) begin
      tests_failed++;
      $display("FAIL basic_add_ovf: got mis=%0b vec=%0d err=%0d, want 0 1 0",
               bus.mismatch, bus.vec_cnt, bus.err_cnt);
    end
    cycle(1'b0, 1'b1, 4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0);
    tests_run++;
    if ({bus.mismatch, bus.vec_cnt, bus.err_cnt} !== {1'b0, 16'd2, 16'd0}) begin
      tests_failed++;
      $display("FAIL basic_sub_borrow: got mis=%0b vec=%0d err=%0d, want 0 2 0",
               bus.mismatch, bus.vec_cnt, bus.err_cnt);
    end
    cycle(1'b0, 1'b1, 4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b1);
    tests_run++;
    if ({bus.mismatch, bus.err_cnt, bus.first_err_valid, bus.first_err_x, bus.first_err_y,
         bus.first_err_cin} !== {1'b1, 16'd1, 1'b1, 4'b0000, 4'b0001, 1'b1}) begin
      tests_failed++;
      $display("FAIL forced_v_err: got mis=%0b err=%0d fv=%0b fx=%h fy=%h fc=%0b, want 1 1 1 0 1 1",
               bus.mismatch, bus.err_cnt, bus.first_err_valid, bus.first_err_x,
               bus.first_err_y, bus.first_err_cin);
    end
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tests_run++;
    if (bus.mismatch !== 1'b0) begin
      tests_failed++;
      $display("FAIL mismatch_pulse: got %0b, want 0", bus.mismatch);
    end
  endtask

  // Full back-to-back sweep; optionally inverts cout on x=1000, y=0001, cin=1
  task automatic test_sweep(input logic inject);
    logic [5:0] r;
    logic [3:0] a, b;
    logic [15:0] want_err;
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      for (int xi = -8; xi < 8; xi++) begin
        for (int yi = -8; yi < 8; yi++) begin
          a = 4'(xi); b = 4'(yi);
          r = ref_result(a, b, 1'(c));
          if (inject && a == 4'b1000 && b == 4'b0001 && c == 1) r[5] = ~r[5];
          cycle(1'b0, 1'b1, a, b, 1'(c), r[3:0], r[5], r[4]);
          tests_run++;
          if ({bus.mismatch, bus.err_cnt, bus.vec_cnt, bus.done} !== {m_mis, m_err, m_vec, m_done}) begin
            tests_failed++;
            $display("FAIL sweep_step x=%h y=%h c=%0d: got mis=%0b err=%0d vec=%0d done=%0b, want %0b %0d %0d %0b",
                     a, b, c, bus.mismatch, bus.err_cnt, bus.vec_cnt, bus.done,
                     m_mis, m_err, m_vec, m_done);
          end
        end
      end
    end
`ifdef ADD_SUB_CHK_COUT_EN
    want_err = inject ? 16'd1 : 16'd0;
`else
    want_err = 16'd0;
`endif
    tests_run++;
    if ({bus.done, bus.vec_cnt, bus.err_cnt} !== {1'b1, 16'd512, want_err}) begin
      tests_failed++;
      $display("FAIL sweep_end inject=%0b: got done=%0b vec=%0d err=%0d, want 1 512 %0d",
               inject, bus.done, bus.vec_cnt, bus.err_cnt, want_err);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 4'd9, 1'b1, 1'b1);
    tests_run++;
    if ({bus.done, bus.vec_cnt, bus.err_cnt, bus.mismatch} !== {1'b1, 16'd512, want_err, 1'b0}) begin
      tests_failed++;
      $display("FAIL after_done: got done=%0b vec=%0d err=%0d mis=%0b, want 1 512 %0d 0",
               bus.done, bus.vec_cnt, bus.err_cnt, bus.mismatch, want_err);
    end
  endtask

  task automatic test_random();
    logic [5:0] r;
    logic [3:0] a, b;
    logic       c, vl;
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      a  = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
      vl = ($urandom_range(3, 0) != 0);
      r  = ref_result(a, b, c);
      if ($urandom_range(3, 0) == 0) r = r ^ (6'd1 << $urandom_range(5, 0));
      cycle(1'b0, vl, a, b, c, r[3:0], r[5], r[4]);
      tests_run++;
      if ({bus.mismatch, bus.err_cnt, bus.vec_cnt, bus.done} !== {m_mis, m_err, m_vec, m_done}) begin
        tests_failed++;
        $display("FAIL random_step %0d: got mis=%0b err=%0d vec=%0d done=%0b, want %0b %0d %0d %0b",
                 i, bus.mismatch, bus.err_cnt, bus.vec_cnt, bus.done, m_mis, m_err, m_vec, m_done);
      end
    end
    tests_run++;
    if ({bus.first_err_valid, bus.first_err_x, bus.first_err_y, bus.first_err_cin} !==
        {m_fv, m_fx, m_fy, m_fc}) begin
      tests_failed++;
      $display("FAIL random_capture: got fv=%0b fx=%h fy=%h fc=%0b, want %0b %h %h %0b",
               bus.first_err_valid, bus.first_err_x, bus.first_err_y, bus.first_err_cin,
               m_fv, m_fx, m_fy, m_fc);
    end
  endtask

  task automatic test_start_collision();
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'd2, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'd5, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);
    tests_run++;
    if ({bus.err_cnt, bus.first_err_x, bus.first_err_y} !== {16'd2, 4'd2, 4'd3}) begin
      tests_failed++;
      $display("FAIL two_errors: got err=%0d fx=%h fy=%h, want 2 2 3",
               bus.err_cnt, bus.first_err_x, bus.first_err_y);
    end
    cycle(1'b1, 1'b1, 4'd6, 4'd6, 1'b0, 4'd1, 1'b0, 1'b1);
    tests_run++;
    if ({bus.mismatch, bus.err_cnt, bus.vec_cnt, bus.first_err_valid, bus.first_err_x,
         bus.first_err_y, bus.first_err_cin, bus.done} !== 44'd0) begin
      tests_failed++;
      $display("FAIL start_wins: got mis=%0b err=%0d vec=%0d fv=%0b fx=%h fy=%h fc=%0b, want all 0",
               bus.mismatch, bus.err_cnt, bus.vec_cnt, bus.first_err_valid,
               bus.first_err_x, bus.first_err_y, bus.first_err_cin);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 3) cycle(1'b0, 1'b1, 4'd4, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0);
      else good_vec(4'($urandom), 4'($urandom), 1'($urandom));
    end
    tests_run++;
    if ({bus.vec_cnt, bus.err_cnt, bus.first_err_valid} !== {16'd100, 16'd10, 1'b1}) begin
      tests_failed++;
      $display("FAIL pre_reset: got vec=%0d err=%0d fv=%0b, want 100 10 1",
               bus.vec_cnt, bus.err_cnt, bus.first_err_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.mismatch, bus.err_cnt, bus.vec_cnt, bus.done, bus.first_err_valid,
         bus.first_err_x, bus.first_err_y, bus.first_err_cin} !== 44'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got err=%0d vec=%0d fv=%0b fx=%h, want all 0",
               bus.err_cnt, bus.vec_cnt, bus.first_err_valid, bus.first_err_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    m_run = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 4'd0, 1'b1, 1'b1);
    tests_run++;
    if ({bus.vec_cnt, bus.err_cnt, bus.mismatch, bus.done} !== 34'd0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got vec=%0d err=%0d mis=%0b done=%0b, want 0 0 0 0",
               bus.vec_cnt, bus.err_cnt, bus.mismatch, bus.done);
    end
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    good_vec(4'd9, 4'd12, 1'b1);
    tests_run++;
    if ({bus.vec_cnt, bus.err_cnt} !== {16'd1, 16'd0}) begin
      tests_failed++;
      $display("FAIL restart: got vec=%0d err=%0d, want 1 0", bus.vec_cnt, bus.err_cnt);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    test_reset();
    test_basic();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_random();
    test_start_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
